// File: rtl/pam_gray_mapper.sv
// rtl/pam_gray_mapper.sv - serial bit to PAM-N Gray symbol mapper with output FIFO (optional PRBS source: PAM_GRAY_MAPPER_PRBS_EN)
module pam_gray_mapper #(
    parameter int BITS_PER_SYM = 2,
    parameter int DEPTH        = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      data_in,
    input  logic                      data_in_valid,
`ifdef PAM_GRAY_MAPPER_PRBS_EN
    input  logic                      prbs_en,
`endif
    output logic                      data_in_ready,
    input  logic                      flush,
    input  logic                      gray_bypass,
    output logic [BITS_PER_SYM-1:0]   symbol_out,
    output logic                      symbol_out_valid,
    input  logic                      symbol_out_ready,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [15:0]               sym_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BITS_PER_SYM + 1);

    logic [BITS_PER_SYM-1:0] sh;
    logic [CW-1:0]           bcnt;
    logic [BITS_PER_SYM-1:0] mem [DEPTH];
    logic [AW-1:0]           wptr;
    logic [AW-1:0]           rptr;

    logic                    src_bit;
    logic                    src_valid;
    logic                    fifo_full;
    logic                    accept;
    logic [BITS_PER_SYM-1:0] sh_acc;
    logic [CW-1:0]           bcnt_acc;
    logic                    word_done;
    logic                    flush_ok;
    logic                    push;
    logic                    pop;
    logic [BITS_PER_SYM-1:0] push_data;

`ifdef PAM_GRAY_MAPPER_PRBS_EN
    logic [6:0] lfsr;

    // PRBS7 (x^7+x^6+1) replaces the serial input while enabled; it only steps when a bit is taken
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= 7'h7F;
        end else if (prbs_en && data_in_ready) begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end

    assign src_bit   = prbs_en ? lfsr[6] : data_in;
    assign src_valid = prbs_en | data_in_valid;
`else
    assign src_bit   = data_in;
    assign src_valid = data_in_valid;
`endif

    // Input is held off whenever the FIFO is full, even for a bit that would not complete a symbol
    assign fifo_full        = (fifo_level == LW'(DEPTH));
    assign data_in_ready    = !fifo_full;
    assign accept           = src_valid && data_in_ready;
    assign pop              = symbol_out_ready && (fifo_level != '0);
    assign symbol_out       = mem[rptr];
    assign symbol_out_valid = (fifo_level != '0);

    // Bits are placed directly at their MSB-first position, so a partial word is already left-aligned
    always_comb begin
        sh_acc = sh;
        for (int i = 0; i < BITS_PER_SYM; i++) begin
            if (accept && (bcnt == CW'(BITS_PER_SYM - 1 - i))) begin
                sh_acc[i] = src_bit;
            end
        end
        bcnt_acc  = bcnt + CW'(accept);
        word_done = (bcnt_acc == CW'(BITS_PER_SYM));
        flush_ok  = flush && (bcnt_acc != '0) && !word_done && !fifo_full;
        push      = word_done || flush_ok;
        push_data = gray_bypass ? sh_acc : (sh_acc ^ (sh_acc >> 1));
    end

    // Accumulator: clears after every FIFO write, otherwise keeps collecting bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh   <= '0;
            bcnt <= '0;
        end else if (push) begin
            sh   <= '0;
            bcnt <= '0;
        end else begin
            sh   <= sh_acc;
            bcnt <= bcnt_acc;
        end
    end

    // FIFO storage and pointers; power-of-two depth lets the pointers wrap on overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Occupancy tracks push/pop; a simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Popped-symbol counter, free-running with natural 16-bit wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sym_count <= '0;
        end else if (pop) begin
            sym_count <= sym_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pam_gray_mapper.sv
// tb/tb_pam_gray_mapper.sv - scoreboard bench for pam_gray_mapper at PAM4 and PAM8
module tb_pam_gray_mapper;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, din, dvld, flush, byp, srdy, prbs_en;
    logic rdy2, vld2, rdy3, vld3;
    logic [1:0] sym2;
    logic [2:0] sym3;
    logic [2:0] lev2, lev3;
    logic [15:0] cnt2, cnt3;

    int assertions = 0;
    int failures = 0;

    pam_gray_mapper #(.BITS_PER_SYM(2), .DEPTH(DEPTH)) u2 (
        .clk(clk), .reset_n(rst_n), .data_in(din), .data_in_valid(dvld),
`ifdef PAM_GRAY_MAPPER_PRBS_EN
        .prbs_en(prbs_en),
`endif
        .data_in_ready(rdy2), .flush(flush), .gray_bypass(byp),
        .symbol_out(sym2), .symbol_out_valid(vld2), .symbol_out_ready(srdy),
        .fifo_level(lev2), .sym_count(cnt2)
    );

    pam_gray_mapper #(.BITS_PER_SYM(3), .DEPTH(DEPTH)) u3 (
        .clk(clk), .reset_n(rst_n), .data_in(din), .data_in_valid(dvld),
`ifdef PAM_GRAY_MAPPER_PRBS_EN
        .prbs_en(prbs_en),
`endif
        .data_in_ready(rdy3), .flush(flush), .gray_bypass(byp),
        .symbol_out(sym3), .symbol_out_valid(vld3), .symbol_out_ready(srdy),
        .fifo_level(lev3), .sym_count(cnt3)
    );

    // reference model state, index 0 = PAM4 instance, 1 = PAM8 instance
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    int         mcnt[2];
    int         mlev[2];
    int         mscnt[2];
    logic [3:0] mword[2];
    logic [6:0] mlfsr[2];
    logic [3:0] osym[2];
    int         olev[2];
    logic       ovld[2], ordy[2];
    logic [15:0] ocnt[2];
    int         m_bps, m_cnt;
    logic       m_erdy, m_bval, m_bit, m_acc, m_push, m_pop;
    logic [3:0] m_wrd, m_exp;

    function automatic logic [3:0] enc(input logic [3:0] w, input logic b);
        return b ? w : (w ^ (w >> 1));
    endfunction

    // model steps on the falling edge with the inputs that the next rising edge will sample
    always @(negedge clk) begin
        osym[0] = {2'b00, sym2}; osym[1] = {1'b0, sym3};
        olev[0] = int'(lev2);    olev[1] = int'(lev3);
        ovld[0] = vld2;          ovld[1] = vld3;
        ordy[0] = rdy2;          ordy[1] = rdy3;
        ocnt[0] = cnt2;          ocnt[1] = cnt3;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                mcnt[k] = 0; mlev[k] = 0; mscnt[k] = 0; mword[k] = 4'd0; mlfsr[k] = 7'h7F;
            end
            q0.delete();
            q1.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_bps  = (k == 0) ? 2 : 3;
                m_erdy = (mlev[k] < DEPTH);
                assertions += 4;
                if (olev[k] !== mlev[k]) begin
                    failures++; $display("FAIL sb_level dut%0d: got %0d expected %0d", k, olev[k], mlev[k]);
                end
                if (ovld[k] !== (mlev[k] > 0)) begin
                    failures++; $display("FAIL sb_valid dut%0d: got %0b expected %0b", k, ovld[k], mlev[k] > 0);
                end
                if (ordy[k] !== m_erdy) begin
                    failures++; $display("FAIL sb_ready dut%0d: got %0b expected %0b", k, ordy[k], m_erdy);
                end
                if (ocnt[k] !== 16'(mscnt[k])) begin
                    failures++; $display("FAIL sb_count dut%0d: got %0d expected %0d", k, ocnt[k], mscnt[k]);
                end
                m_bval = prbs_en ? 1'b1 : dvld;
                m_bit  = prbs_en ? mlfsr[k][6] : din;
                m_acc  = m_bval && m_erdy;
                if (m_acc && prbs_en) mlfsr[k] = {mlfsr[k][5:0], mlfsr[k][6] ^ mlfsr[k][5]};
                m_cnt = mcnt[k] + (m_acc ? 1 : 0);
                m_wrd = mword[k];
                if (m_acc) m_wrd = m_wrd | (4'(m_bit) << (m_bps - 1 - mcnt[k]));
                m_push = (m_cnt == m_bps) || (flush && m_cnt > 0 && m_cnt < m_bps && m_erdy);
                m_pop  = srdy && (mlev[k] > 0);
                if (m_pop) begin
                    m_exp = (k == 0) ? q0.pop_front() : q1.pop_front();
                    assertions++;
                    if (osym[k] !== m_exp) begin
                        failures++; $display("FAIL sb_symbol dut%0d: got %0d expected %0d", k, osym[k], m_exp);
                    end
                    mscnt[k] = (mscnt[k] + 1) & 16'hFFFF;
                end
                if (m_push) begin
                    if (k == 0) q0.push_back(enc(m_wrd, byp));
                    else        q1.push_back(enc(m_wrd, byp));
                    mword[k] = 4'd0;
                    mcnt[k]  = 0;
                end else begin
                    mword[k] = m_wrd;
                    mcnt[k]  = m_cnt;
                end
                mlev[k] = mlev[k] + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        din = b; dvld = 1'b1;
        cyc();
        dvld = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; din = 1'b0; dvld = 1'b0; flush = 1'b0; byp = 1'b0; srdy = 1'b0; prbs_en = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic drain();
        srdy = 1'b1; dvld = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!vld2 && !vld3) break;
            cyc();
        end
        assertions++;
        if (vld2 || vld3) begin
            failures++; $display("FAIL drain_timeout: valid2=%0b valid3=%0b required 0", vld2, vld3);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; din = 1'b0; dvld = 1'b0; flush = 1'b0; byp = 1'b0; srdy = 1'b0; prbs_en = 1'b0;
        cyc();
        assertions += 5;
        if (lev2 !== 3'd0 || lev3 !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d/%0d required 0", lev2, lev3); end
        if (vld2 !== 1'b0 || vld3 !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b/%0b required 0", vld2, vld3); end
        if (sym2 !== 2'd0 || sym3 !== 3'd0) begin failures++; $display("FAIL reset_symbol: got %0d/%0d required 0", sym2, sym3); end
        if (cnt2 !== 16'd0 || cnt3 !== 16'd0) begin failures++; $display("FAIL reset_count: got %0d/%0d required 0", cnt2, cnt3); end
        rst_n = 1'b1;
        cyc();
        if (rdy2 !== 1'b1 || rdy3 !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b/%0b required 1", rdy2, rdy3); end
    endtask

    task automatic test_gray_pam4();
        do_reset();
        srdy = 1'b1; byp = 1'b0;
        send(1'b1); send(1'b0);
        assertions++;
        if (vld2 !== 1'b1 || sym2 !== 2'd3) begin failures++; $display("FAIL pam4_first: got v=%0b s=%0d required v=1 s=3", vld2, sym2); end
        send(1'b1); send(1'b1);
        assertions++;
        if (vld2 !== 1'b1 || sym2 !== 2'd2) begin failures++; $display("FAIL pam4_second: got v=%0b s=%0d required v=1 s=2", vld2, sym2); end
        cyc();
        assertions++;
        if (cnt2 !== 16'd2) begin failures++; $display("FAIL pam4_count: got %0d required 2", cnt2); end
        drain();
    endtask

    task automatic test_bypass_pam8();
        do_reset();
        srdy = 1'b1; byp = 1'b1;
        send(1'b1); send(1'b0); send(1'b1);
        assertions++;
        if (vld3 !== 1'b1 || sym3 !== 3'd5) begin failures++; $display("FAIL pam8_binary: got v=%0b s=%0d required v=1 s=5", vld3, sym3); end
        byp = 1'b0;
        send(1'b1); send(1'b0); send(1'b1);
        assertions++;
        if (vld3 !== 1'b1 || sym3 !== 3'd7) begin failures++; $display("FAIL pam8_gray: got v=%0b s=%0d required v=1 s=7", vld3, sym3); end
        drain();
    endtask

    task automatic test_flush();
        do_reset();
        send(1'b1);
        assertions++;
        if (vld3 !== 1'b0) begin failures++; $display("FAIL flush_early: got valid %0b required 0", vld3); end
        flush = 1'b1; cyc(); flush = 1'b0;
        assertions++;
        if (vld3 !== 1'b1 || sym3 !== 3'd6 || lev3 !== 3'd1) begin
            failures++; $display("FAIL flush_partial: got v=%0b s=%0d l=%0d required v=1 s=6 l=1", vld3, sym3, lev3);
        end
        flush = 1'b1; cyc(); flush = 1'b0;
        assertions++;
        if (lev3 !== 3'd1) begin failures++; $display("FAIL flush_noop: got level %0d required 1", lev3); end
        send(1'b0); send(1'b1); send(1'b1);
        assertions++;
        if (lev3 !== 3'd2) begin failures++; $display("FAIL flush_cleared: got level %0d required 2", lev3); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [9:0] bits;
        bits = 10'b1101001011;
        do_reset();
        for (int i = 0; i < 8; i++) send(bits[9 - i]);
        assertions++;
        if (lev2 !== 3'd4 || rdy2 !== 1'b0) begin failures++; $display("FAIL bp_full: got l=%0d r=%0b required l=4 r=0", lev2, rdy2); end
        din = bits[1]; dvld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            assertions++;
            if (lev2 !== 3'd4 || rdy2 !== 1'b0) begin failures++; $display("FAIL bp_hold: got l=%0d r=%0b required l=4 r=0", lev2, rdy2); end
        end
        srdy = 1'b1;
        cyc();
        assertions++;
        if (lev2 !== 3'd3) begin failures++; $display("FAIL bp_pop_full: got level %0d required 3", lev2); end
        cyc();
        assertions++;
        if (lev2 !== 3'd2) begin failures++; $display("FAIL bp_bit9: got level %0d required 2", lev2); end
        din = bits[0];
        cyc();
        dvld = 1'b0;
        assertions++;
        if (lev2 !== 3'd2) begin failures++; $display("FAIL bp_push_pop: got level %0d required 2", lev2); end
        drain();
        assertions++;
        if (cnt2 !== 16'd5) begin failures++; $display("FAIL bp_count: got %0d required 5", cnt2); end
    endtask

    task automatic test_reset_mid();
        logic [6:0] bits;
        bits = 7'b1100101;
        do_reset();
        for (int i = 0; i < 7; i++) send(bits[6 - i]);
        assertions++;
        if (lev2 !== 3'd3) begin failures++; $display("FAIL mid_queued: got level %0d required 3", lev2); end
        rst_n = 1'b0;
        #2;
        assertions++;
        if (lev2 !== 3'd0 || vld2 !== 1'b0 || sym2 !== 2'd0 || cnt2 !== 16'd0 || rdy2 !== 1'b1) begin
            failures++; $display("FAIL mid_reset: got l=%0d v=%0b s=%0d c=%0d r=%0b required 0,0,0,0,1", lev2, vld2, sym2, cnt2, rdy2);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        srdy = 1'b1;
        send(1'b0); send(1'b1);
        assertions++;
        if (vld2 !== 1'b1 || sym2 !== 2'd1) begin failures++; $display("FAIL mid_after: got v=%0b s=%0d required v=1 s=1", vld2, sym2); end
        drain();
    endtask

`ifdef PAM_GRAY_MAPPER_PRBS_EN
    task automatic test_prbs();
        logic [1:0] got[4];
        logic [1:0] want[4];
        int n;
        want = '{2'd2, 2'd2, 2'd2, 2'd3};
        n = 0;
        do_reset();
        srdy = 1'b1; prbs_en = 1'b1;
        for (int i = 0; i < 40 && n < 4; i++) begin
            cyc();
            if (vld2) begin got[n] = sym2; n++; end
        end
        prbs_en = 1'b0;
        assertions++;
        if (n != 4) begin
            failures++; $display("FAIL prbs_timeout: got %0d symbols required 4", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                assertions++;
                if (got[i] !== want[i]) begin failures++; $display("FAIL prbs_sym%0d: got %0d required %0d", i, got[i], want[i]); end
            end
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_gray_pam4();
        test_bypass_pam8();
        test_flush();
        test_back_to_back();
        test_reset_mid();
`ifdef PAM_GRAY_MAPPER_PRBS_EN
        test_prbs();
`endif
        cyc(); cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
